// File: rtl/thermo_dec.sv
// Thermometer-code decoder for the LED sequencer: decodes the ones count,
// flags illegal codes and sequence violations, and counts errors and wraps.
module thermo_dec #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             ck,
    input  logic             rs,
    input  logic [7:0]       leds,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [3:0]       level,
    output logic             out_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       legal;
    logic [3:0] dec;
    logic       seq_nx;
    logic       wrap_evt;
    logic       err_evt;

    always_comb begin
        legal = 1'b1;
        dec   = '0;
        case (leds)
            8'h00:   dec = 4'd0;
            8'h01:   dec = 4'd1;
            8'h03:   dec = 4'd2;
            8'h07:   dec = 4'd3;
            8'h0F:   dec = 4'd4;
            8'h1F:   dec = 4'd5;
            8'h3F:   dec = 4'd6;
            8'h7F:   dec = 4'd7;
            8'hFF:   dec = 4'd8;
            default: legal = 1'b0;
        endcase
    end

    // level doubles as the previous legal sample: it only moves on legal samples
    always_comb begin
        state_nx = state;
        seq_nx   = 1'b0;
        wrap_evt = 1'b0;
        if (in_valid) begin
            if (!legal) begin
                state_nx = ERR;
            end else begin
                case (state)
                    IDLE: begin
                        if (dec == 4'd1) begin
                            state_nx = TRACK;
                        end else if (dec != 4'd0) begin
                            seq_nx   = 1'b1;
                            state_nx = ERR;
                        end
                    end
                    TRACK: begin
                        if (dec == 4'd0) begin
                            state_nx = IDLE;
                        end else if (level == 4'd8 && dec == 4'd1) begin
                            wrap_evt = 1'b1;
                        end else if (dec != level && dec != level + 4'd1) begin
                            seq_nx   = 1'b1;
                            state_nx = ERR;
                        end
                    end
                    ERR: begin
                        if (dec == 4'd1) begin
                            state_nx = TRACK;
                        end else if (dec == 4'd0) begin
                            state_nx = IDLE;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    assign err_evt = in_valid && (!legal || seq_nx);
    assign locked  = (state == TRACK);

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            state     <= IDLE;
            level     <= '0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= in_valid;
            code_err  <= in_valid && !legal;
            seq_err   <= seq_nx;
            if (in_valid && legal) begin
                level <= dec;
            end
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            if (err_evt && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (wrap_evt && wrap_cnt != '1) begin
                wrap_cnt <= wrap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thermo_dec.sv
// Bench for thermo_dec: directed vector table, hand sequences for reset and
// saturation, then random stimulus against a ones-count reference model.
module tb_thermo_dec;

    logic       ck;
    logic       rs;
    logic [7:0] leds;
    logic       in_valid;
    logic       clr_cnt;

    logic [3:0] level,  level2;
    logic       out_valid, out_valid2;
    logic       code_err, code_err2;
    logic       seq_err, seq_err2;
    logic       locked, locked2;
    logic [7:0] err_cnt, wrap_cnt;
    logic [1:0] err_cnt2, wrap_cnt2;

    thermo_dec #(.CNT_W(8)) dut (
        .ck(ck), .rs(rs), .leds(leds), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .level(level), .out_valid(out_valid), .code_err(code_err), .seq_err(seq_err),
        .locked(locked), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    thermo_dec #(.CNT_W(2)) dut2 (
        .ck(ck), .rs(rs), .leds(leds), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .level(level2), .out_valid(out_valid2), .code_err(code_err2), .seq_err(seq_err2),
        .locked(locked2), .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: mode 0=idle, 1=tracking, 2=error; counters unbounded, saturated on compare
    int m_mode, m_level, m_err, m_wrap;
    int m_ov, m_ce, m_se;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_level = 0; m_err = 0; m_wrap = 0;
        m_ov = 0; m_ce = 0; m_se = 0;
    endtask

    task automatic model_edge(input logic [7:0] l, input logic v, input logic c);
        int ones, n;
        bit ok;
        m_ov = v; m_ce = 0; m_se = 0;
        if (v) begin
            ones = $countones(l);
            ok   = (int'(l) == (1 << ones) - 1);
            if (!ok) begin
                m_ce = 1;
                m_mode = 2;
            end else begin
                n = ones;
                if (m_mode == 0) begin
                    if (n == 1) m_mode = 1;
                    else if (n != 0) begin m_se = 1; m_mode = 2; end
                end else if (m_mode == 1) begin
                    if (n == 0) m_mode = 0;
                    else if (m_level == 8 && n == 1) m_wrap++;
                    else if (n != m_level && n != m_level + 1) begin m_se = 1; m_mode = 2; end
                end else begin
                    if (n == 1) m_mode = 1;
                    else if (n == 0) m_mode = 0;
                end
                m_level = n;
            end
            if (m_ce != 0 || m_se != 0) m_err++;
        end
        if (c) begin
            m_err = 0;
            m_wrap = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},     int'(level),     m_level);
        chk({tag, ".out_valid"}, int'(out_valid), m_ov);
        chk({tag, ".code_err"},  int'(code_err),  m_ce);
        chk({tag, ".seq_err"},   int'(seq_err),   m_se);
        chk({tag, ".locked"},    int'(locked),    (m_mode == 1) ? 1 : 0);
        chk({tag, ".err_cnt"},   int'(err_cnt),   sat(m_err, 255));
        chk({tag, ".wrap_cnt"},  int'(wrap_cnt),  sat(m_wrap, 255));
        chk({tag, ".err_cnt2"},  int'(err_cnt2),  sat(m_err, 3));
        chk({tag, ".wrap_cnt2"}, int'(wrap_cnt2), sat(m_wrap, 3));
        chk({tag, ".level2"},    int'(level2),    m_level);
    endtask

    task automatic step(input logic [7:0] l, input logic v, input logic c);
        leds = l; in_valid = v; clr_cnt = c;
        @(posedge ck);
        model_edge(l, v, c);
        #1;
    endtask

    task automatic async_reset(input string tag);
        @(negedge ck);
        #2 rs = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge ck);
        rs = 1'b1;
    endtask

    typedef struct {
        logic [7:0] leds;
        logic       v;
        logic [3:0] lvl;
        logic       ov;
        logic       ce;
        logic       se;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] l, input logic v, input logic [3:0] lvl,
                                input logic ce, input logic se, input logic lk);
        vec_t r;
        r.leds = l; r.v = v; r.lvl = lvl; r.ov = v; r.ce = ce; r.se = se; r.lk = lk;
        return r;
    endfunction

    initial begin
        logic [7:0] rl;
        int k, pick;
        rs = 1'b0; leds = '0; in_valid = 1'b0; clr_cnt = 1'b0;
        #3;
        model_reset();
        check_all("reset");
        @(negedge ck);
        rs = 1'b1;

        // full climb plus one wrap
        tbl.push_back(mk(8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(8'h01, 1, 1, 0, 0, 1));
        tbl.push_back(mk(8'h03, 1, 2, 0, 0, 1));
        tbl.push_back(mk(8'h07, 1, 3, 0, 0, 1));
        tbl.push_back(mk(8'h0F, 1, 4, 0, 0, 1));
        tbl.push_back(mk(8'h1F, 1, 5, 0, 0, 1));
        tbl.push_back(mk(8'h3F, 1, 6, 0, 0, 1));
        tbl.push_back(mk(8'h7F, 1, 7, 0, 0, 1));
        tbl.push_back(mk(8'hFF, 1, 8, 0, 0, 1));
        tbl.push_back(mk(8'h01, 1, 1, 0, 0, 1));
        // illegal code at level 3, then resync
        tbl.push_back(mk(8'h03, 1, 2, 0, 0, 1));
        tbl.push_back(mk(8'h07, 1, 3, 0, 0, 1));
        tbl.push_back(mk(8'h05, 1, 3, 1, 0, 0));
        tbl.push_back(mk(8'h01, 1, 1, 0, 0, 1));
        // skip from 2 to 4, then stay in error silently
        tbl.push_back(mk(8'h03, 1, 2, 0, 0, 1));
        tbl.push_back(mk(8'h0F, 1, 4, 0, 1, 0));
        tbl.push_back(mk(8'h1F, 1, 5, 0, 0, 0));
        // gapped valid with a held source
        tbl.push_back(mk(8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(8'h01, 1, 1, 0, 0, 1));
        tbl.push_back(mk(8'h03, 1, 2, 0, 0, 1));
        tbl.push_back(mk(8'h07, 1, 3, 0, 0, 1));
        tbl.push_back(mk(8'h55, 0, 3, 0, 0, 1));
        tbl.push_back(mk(8'h07, 1, 3, 0, 0, 1));
        tbl.push_back(mk(8'hAA, 0, 3, 0, 0, 1));
        tbl.push_back(mk(8'h07, 1, 3, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].leds, tbl[i].v, 1'b0);
            chk($sformatf("vec%0d.level", i),     int'(level),     int'(tbl[i].lvl));
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(tbl[i].ov));
            chk($sformatf("vec%0d.code_err", i),  int'(code_err),  int'(tbl[i].ce));
            chk($sformatf("vec%0d.seq_err", i),   int'(seq_err),   int'(tbl[i].se));
            chk($sformatf("vec%0d.locked", i),    int'(locked),    int'(tbl[i].lk));
            check_all($sformatf("vec%0d.model", i));
            if (i == 9) begin
                chk("climb.wrap_cnt", int'(wrap_cnt), 1);
                chk("climb.err_cnt",  int'(err_cnt),  0);
            end
            if (i == 12) chk("illegal.err_cnt", int'(err_cnt), 1);
        end

        // four sequence errors saturate the 2-bit counter; clear beats a fifth
        clr_cnt = 1'b1; step(8'h00, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1, 0);
            step(8'h03, 1, 0);
            chk("sat.seq_err", int'(seq_err), 1);
        end
        chk("sat.err_cnt2", int'(err_cnt2), 3);
        chk("sat.err_cnt",  int'(err_cnt),  4);
        step(8'h00, 1, 0);
        step(8'h03, 1, 1);
        chk("clr.err_cnt2", int'(err_cnt2), 0);
        chk("clr.err_cnt",  int'(err_cnt),  0);
        chk("clr.level",    int'(level),    2);
        check_all("clr");

        // async reset at level 6, then first sample judged from idle
        step(8'h00, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            rl = 8'((1 << i) - 1);
            step(rl, 1, 0);
        end
        chk("pre_rst.level", int'(level), 6);
        async_reset("midrst");
        chk("midrst.level",  int'(level),  0);
        chk("midrst.locked", int'(locked), 0);
        step(8'h03, 1, 0);
        chk("postrst.seq_err", int'(seq_err), 1);
        check_all("postrst");

        for (int i = 0; i < 3000; i++) begin
            pick = $urandom_range(0, 99);
            k = $urandom_range(0, 4);
            if (k == 0) k = 0;
            else if (k == 1) k = 1;
            else if (k == 2) k = m_level;
            else if (k == 3) k = (m_level < 8) ? m_level + 1 : 1;
            else k = $urandom_range(0, 8);
            rl = (pick < 80) ? 8'((1 << k) - 1) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
            step(rl, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
